// File: rtl/mont_pkg.sv
// Shared types and defaults for the montgomery exponentiation controller,
// its multiplier handshake block and the benches that drive them.
package mont_pkg;

    // Default operand / modulus width; R = 2^MONT_WIDTH.
    localparam int MONT_WIDTH = 256;

    // Exponentiation controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TO_MONT_X,
        ST_TO_MONT_ONE,
        ST_SQUARE,
        ST_MULT,
        ST_FROM_MONT,
        ST_DONE
    } mont_state_t;

    // Multiplier handshake states.
    typedef enum logic [1:0] {
        MM_IDLE,
        MM_WAIT,
        MM_ISSUE
    } mm_state_t;

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Bus between the exponentiation controller and the external montgomery
// multiplier core.
//
// Handshake: the controller raises mm_start only while mm_done is low and
// holds mm_A/mm_B/mm_P stable with mm_start high until the core answers with
// mm_done. mm_M is taken in the first cycle where mm_start and mm_done are
// both high; mm_start then drops for at least one cycle. An mm_done seen
// while mm_start is low carries no result and is ignored.
interface mont_exp_ctrl_if #(parameter int WIDTH = mont_pkg::MONT_WIDTH);

    logic             mm_start;
    logic [WIDTH-1:0] mm_A;
    logic [WIDTH-1:0] mm_B;
    logic [WIDTH-1:0] mm_P;
    logic [WIDTH-1:0] mm_M;
    logic             mm_done;

    modport master (output mm_start, mm_A, mm_B, mm_P, input mm_M, mm_done);
    modport slave  (input mm_start, mm_A, mm_B, mm_P, output mm_M, mm_done);

endinterface

// File: rtl/mont_mm_if.sv
// Owns the mm_start/mm_done handshake: turns a one-cycle request from the
// controller into a held multiplier request and returns a one-cycle ack
// together with the captured product.
module mont_mm_if
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic             o_ack,
    output logic [WIDTH-1:0] o_m,
    output mm_state_t        o_state,
    mont_exp_ctrl_if.master  mm
);

    mm_state_t        r_state;
    mm_state_t        w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_m;
    logic             r_ack;
    logic             w_capture;

    assign w_capture   = (r_state == MM_ISSUE) && mm.mm_done;
    assign mm.mm_start = (r_state == MM_ISSUE);
    assign mm.mm_A     = r_a;
    assign mm.mm_B     = r_b;
    assign mm.mm_P     = r_p;
    assign o_ack       = r_ack;
    assign o_m         = r_m;
    assign o_state     = r_state;

    // Next state: wait out a stale mm_done before issuing, then hold until answered.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MM_IDLE:  if (i_req) w_next = mm.mm_done ? MM_WAIT : MM_ISSUE;
            MM_WAIT:  if (!mm.mm_done) w_next = MM_ISSUE;
            MM_ISSUE: if (mm.mm_done) w_next = MM_IDLE;
            default:  w_next = MM_IDLE;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MM_IDLE;
        else        r_state <= w_next;
    end

    // Operand latch on request, product capture and ack pulse on answer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_m   <= '0;
            r_ack <= 1'b0;
        end else begin
            if (r_state == MM_IDLE && i_req) begin
                r_a <= i_a;
                r_b <= i_b;
                r_p <= i_p;
            end
            r_ack <= w_capture;
            if (w_capture) r_m <= mm.mm_M;
        end
    end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right modular exponentiation controller driving an external
// montgomery multiplier (A*B*R^-1 mod P).
// Optional build macro MONT_EXP_CONST_TIME_EN: run MULT for every exponent
// bit and discard the product when the bit is 0, so the multiplication count
// no longer depends on the exponent.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err,
    output logic             busy,
    output mont_state_t      o_dbg_state,
    output mm_state_t        o_dbg_mm_state,
    mont_exp_ctrl_if.master  mm
);

    localparam int IW = $clog2(WIDTH);

    mont_state_t      r_state;
    mont_state_t      w_next;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_xb;
    logic [IW-1:0]    r_idx;
    logic             r_err;
    logic             r_issued;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_m;
    logic             w_ack;
    logic             w_req;
    logic             w_bit;
    logic             w_last;
    logic             w_mm_state;

    assign w_bit      = r_exp[r_idx];
    assign w_last     = (r_idx == '0);
    assign w_mm_state = (r_state == ST_TO_MONT_X) || (r_state == ST_TO_MONT_ONE) ||
                        (r_state == ST_SQUARE)    || (r_state == ST_MULT) ||
                        (r_state == ST_FROM_MONT);
    // One request per multiplication state visit; cleared by the ack.
    assign w_req      = w_mm_state && !r_issued;

    assign done        = (r_state == ST_DONE);
    assign err         = done && r_err;
    assign result      = (done && !r_err) ? r_acc : '0;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

    mont_mm_if #(.WIDTH(WIDTH)) u_mm (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_req),
        .i_a     (w_op_a),
        .i_b     (w_op_b),
        .i_p     (r_p),
        .o_ack   (w_ack),
        .o_m     (w_m),
        .o_state (o_dbg_mm_state),
        .mm      (mm)
    );

    // Next state and multiplier operands for the current step.
    always_comb begin
        w_next = r_state;
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            ST_IDLE: if (start) w_next = P[0] ? ST_TO_MONT_X : ST_DONE;
            ST_TO_MONT_X: begin
                w_op_a = r_base;
                w_op_b = r_r2;
                if (w_ack) w_next = ST_TO_MONT_ONE;
            end
            ST_TO_MONT_ONE: begin
                w_op_a = WIDTH'(1);
                w_op_b = r_r2;
                if (w_ack) w_next = ST_SQUARE;
            end
            ST_SQUARE: begin
                w_op_a = r_acc;
                w_op_b = r_acc;
`ifdef MONT_EXP_CONST_TIME_EN
                if (w_ack) w_next = ST_MULT;
`else
                if (w_ack) begin
                    if (w_bit)       w_next = ST_MULT;
                    else if (w_last) w_next = ST_FROM_MONT;
                    else             w_next = ST_SQUARE;
                end
`endif
            end
            ST_MULT: begin
                w_op_a = r_acc;
                w_op_b = r_xb;
                if (w_ack) w_next = w_last ? ST_FROM_MONT : ST_SQUARE;
            end
            ST_FROM_MONT: begin
                w_op_a = r_acc;
                w_op_b = WIDTH'(1);
                if (w_ack) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Operand latch at start, accumulator/bit-index updates on each ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_exp    <= '0;
            r_p      <= '0;
            r_r2     <= '0;
            r_acc    <= '0;
            r_xb     <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_issued <= 1'b0;
        end else begin
            if (w_req)      r_issued <= 1'b1;
            else if (w_ack) r_issued <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_base <= base;
                    r_exp  <= exp;
                    r_p    <= P;
                    r_r2   <= R2;
                    r_err  <= ~P[0];
                    r_idx  <= IW'(WIDTH - 1);
                    r_acc  <= '0;
                    r_xb   <= '0;
                end
                ST_TO_MONT_X: if (w_ack) r_xb <= w_m;
                ST_TO_MONT_ONE, ST_FROM_MONT: if (w_ack) r_acc <= w_m;
                ST_SQUARE: if (w_ack) begin
                    r_acc <= w_m;
                    if (w_next == ST_SQUARE) r_idx <= r_idx - IW'(1);
                end
                // A zero exponent bit keeps acc: the product is discarded.
                ST_MULT: if (w_ack) begin
                    if (w_bit)   r_acc <= w_m;
                    if (!w_last) r_idx <= r_idx - IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural montgomery core with random latency
// and lingering mm_done, plain-arithmetic modexp reference, directed and
// random operations, mid-operation reset. Honors MONT_EXP_CONST_TIME_EN.
module tb_mont_exp_ctrl;
    import mont_pkg::*;

    localparam int W      = MONT_WIDTH;
    localparam int BUDGET = 20000;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [W-1:0] i_base, i_exp, i_p, i_r2;
    logic [W-1:0] result;
    logic         done, err, busy;
    mont_state_t  dbg_state;
    mm_state_t    dbg_mm_state;

    int total  = 0;
    int bad    = 0;
    int n_req  = 0;
    int hs_viol = 0;

    mont_exp_ctrl_if #(.WIDTH(W)) mm_bus ();

    mont_exp_ctrl #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (i_start),
        .base           (i_base),
        .exp            (i_exp),
        .P              (i_p),
        .R2             (i_r2),
        .result         (result),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .o_dbg_state    (dbg_state),
        .o_dbg_mm_state (dbg_mm_state),
        .mm             (mm_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, b, p);
        logic [2*W-1:0] t;
        t = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, p};
        return t[W-1:0];
    endfunction

    // a*b*2^-W mod p by W modular halvings (p odd).
    function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, b, p);
        logic [W:0] x;
        x = {1'b0, mulmod(a, b, p)};
        for (int i = 0; i < W; i++) x = x[0] ? ((x + {1'b0, p}) >> 1) : (x >> 1);
        return x[W-1:0];
    endfunction

    function automatic logic [W-1:0] r2_of(input logic [W-1:0] p);
        logic [W:0] x;
        x = 1;
        for (int i = 0; i < 2 * W; i++) begin
            x = x << 1;
            if (x >= {1'b0, p}) x = x - {1'b0, p};
        end
        return x[W-1:0];
    endfunction

    // Right-to-left square and multiply on plain residues.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, e, p);
        logic [W-1:0] r, s;
        r = W'(1) % p;
        s = b % p;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = mulmod(r, s, p);
            s = mulmod(s, s, p);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- behavioural multiplier core ----------------
    logic [W-1:0] m_a, m_b, m_p;
    logic         m_busy, m_cap;
    int           m_lat, m_hold;

    // Accept a request, answer after 1-20 cycles, sometimes leave mm_done
    // high (with junk on mm_M) for a few cycles after the capture.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_bus.mm_done <= 1'b0;
            mm_bus.mm_M    <= '0;
            m_busy <= 1'b0;
            m_cap  <= 1'b0;
            m_lat  <= 0;
            m_hold <= 0;
        end else if (m_busy) begin
            if (mm_bus.mm_start !== 1'b1 || mm_bus.mm_A !== m_a ||
                mm_bus.mm_B !== m_b || mm_bus.mm_P !== m_p) hs_viol <= hs_viol + 1;
            if (m_lat == 0) begin
                mm_bus.mm_done <= 1'b1;
                mm_bus.mm_M    <= mont_mul(m_a, m_b, m_p);
                m_busy <= 1'b0;
                m_cap  <= 1'b1;
                m_hold <= $urandom_range(0, 2);
            end else begin
                m_lat <= m_lat - 1;
            end
        end else if (mm_bus.mm_done) begin
            if (m_cap) begin
                if (mm_bus.mm_start !== 1'b1) hs_viol <= hs_viol + 1;
                m_cap <= 1'b0;
            end else if (mm_bus.mm_start !== 1'b0) begin
                hs_viol <= hs_viol + 1;
            end
            if (m_hold == 0) begin
                mm_bus.mm_done <= 1'b0;
            end else begin
                mm_bus.mm_M <= ~mm_bus.mm_M;
                m_hold <= m_hold - 1;
            end
        end else if (mm_bus.mm_start) begin
            m_busy <= 1'b1;
            m_a    <= mm_bus.mm_A;
            m_b    <= mm_bus.mm_B;
            m_p    <= mm_bus.mm_P;
            m_lat  <= $urandom_range(0, 19);
            n_req  <= n_req + 1;
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input string tag, input logic [W-1:0] b, e, p, want);
        int  base_req;
        int  want_cnt;
        bit  got_done;
        base_req = n_req;
`ifdef MONT_EXP_CONST_TIME_EN
        want_cnt = p[0] ? 3 + 2 * W : 0;
`else
        want_cnt = p[0] ? 3 + W + $countones(e) : 0;
`endif
        @(posedge clk); #1;
        i_base  = b;
        i_exp   = e;
        i_p     = p;
        i_r2    = r2_of(p);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start  = 1'b0;
        got_done = done;
        if (!p[0]) begin
            check({tag, "_done_now"}, done, 1);
            check({tag, "_err"}, err, 1);
        end else begin
            check({tag, "_busy"}, busy, 1);
            for (int c = 0; c < BUDGET && !got_done; c++) begin
                @(posedge clk); #1;
                // Inputs and stray starts must not disturb a running operation.
                i_base  = rand_wide();
                i_exp   = rand_wide();
                i_p     = rand_wide();
                i_r2    = rand_wide();
                i_start = ($urandom_range(0, 3) == 0);
                if (done) begin
                    got_done = 1'b1;
                    i_start  = 1'b0;
                end
            end
            check({tag, "_done_seen"}, got_done, 1);
            check({tag, "_err"}, err, 0);
        end
        check({tag, "_result"}, result, want);
        check({tag, "_mm_count"}, W'(n_req - base_req), W'(want_cnt));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] b, e, p;
        int  base_req;
        bit  seen_done;

        rst_n   = 1'b0;
        i_start = 1'b0;
        i_base  = '0;
        i_exp   = '0;
        i_p     = '0;
        i_r2    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_mm_start", mm_bus.mm_start, 0);
        rst_n = 1'b1;

        run_op("p997_e10", W'(2), W'(10), W'(997), W'(27));
        run_op("p89_e4", W'(3), W'(4), W'(89), W'(81));
        run_op("p89_e88", W'(13), W'(88), W'(89), W'(1));
        run_op("exp0", W'(65), W'(0), W'(997), W'(1));
        run_op("exp1", W'(65), W'(1), W'(997), W'(65));
        run_op("p_even", W'(2), W'(10), W'(996), W'(0));

        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                p = rand_wide();
                p[W-1] = 1'b1;
                p[0]   = 1'b1;
                b = rand_wide() % p;
            end else begin
                p = W'($urandom) | W'(1);
                if (p < W'(3)) p = W'(3);
                b = W'($urandom) % p;
            end
            e = W'($urandom);
            e[W-1] = 1'($urandom_range(0, 1));
            run_op("rnd", b, e, p, ref_modexp(b, e, p));
        end

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        i_base  = W'(2);
        i_exp   = W'(10);
        i_p     = W'(997);
        i_r2    = r2_of(W'(997));
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start   = 1'b0;
        base_req  = n_req;
        seen_done = 1'b0;
        for (int c = 0; c < BUDGET && (n_req - base_req) < 100; c++) begin
            @(posedge clk); #1;
            i_start = ($urandom_range(0, 3) == 0);
            if (done) seen_done = 1'b1;
        end
        check("rst_mid_reached_100", W'((n_req - base_req) >= 100), 1);
        i_start = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst_mid_result", result, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mm_start", mm_bus.mm_start, 0);
        check("rst_mid_mm_A", mm_bus.mm_A, 0);
        check("rst_mid_mm_B", mm_bus.mm_B, 0);
        check("rst_mid_mm_P", mm_bus.mm_P, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("rst_mid_no_done", seen_done, 0);
        run_op("rst_rerun", W'(2), W'(10), W'(997), W'(27));

        check("handshake_viol", W'(hs_viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 Parameter: WIDTH, 256, operand/modulus width in bits; R = 2^WIDTH.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request exponentiation; sampled only in IDLE.
REQ-005 Port: base, exp, P, R2  input  WIDTH each  base (< P), exponent, odd modulus, R^2 mod P.
REQ-006 Port: result  output  WIDTH  base^exp mod P; valid while done=1.
REQ-007 Port: done  output  1  one-cycle completion pulse.
REQ-008 Port: err  output  1  one-cycle pulse with done when P is even.
REQ-009 Port: busy  output  1  high from the cycle after accepted start until done.
REQ-010 Port: mm_start  output  1  request to the external montgomery multiplier core.
REQ-011 Port: mm_A, mm_B, mm_P  output  WIDTH each  multiplier operands and modulus.
REQ-012 Port: mm_M, mm_done  input  WIDTH, 1  multiplier result (A*B*R^-1 mod P) and its valid flag.

Function
REQ-013 start=1 in IDLE shall latch base, exp, P, R2 into internal registers; later input changes have no effect.
REQ-014 Multiplier handshake: mm_start shall be raised only when mm_done=0, held with stable mm_A/mm_B/mm_P until mm_done=1, then mm_M captured in that cycle and mm_start dropped for at least one cycle.
REQ-015 FSM states: IDLE, TO_MONT_X (xb=MM(base,R2)), TO_MONT_ONE (acc=MM(1,R2)), SQUARE (acc=MM(acc,acc)), MULT (acc=MM(acc,xb)), FROM_MONT (acc=MM(acc,1)), DONE.
REQ-016 Transitions: IDLE->TO_MONT_X->TO_MONT_ONE->SQUARE; SQUARE->MULT if exp[i]=1 else next bit; MULT->next bit; after bit 0 ->FROM_MONT->DONE->IDLE.
REQ-017 Bit index i shall run WIDTH-1 down to 0 (left-to-right), counter width $clog2(WIDTH).
REQ-018 Multiplication count shall be 3 + WIDTH + popcount(exp) with the feature of REQ-026 disabled.
REQ-019 DONE shall drive result=acc, done=1 for exactly one cycle, busy=0 the following cycle.
REQ-020 exp=0 shall yield result=1 (P>1); exp=1 shall yield result=base.
REQ-021 P[0]=0 at start shall skip all multiplications: next cycle done=1, err=1, result=0.
REQ-022 start while busy shall be ignored; start held high after done shall begin a new operation only after returning to IDLE.
REQ-023 mm_done=1 while mm_start=0 shall be ignored (no capture, no state change).

Reset
REQ-024 rst_n=0 shall asynchronously force IDLE, result=0, done=0, err=0, busy=0, mm_start=0, mm_A/mm_B/mm_P=0, all internal registers 0.
REQ-025 Reset mid-operation shall abandon the operation with no done pulse; next start after release shall run normally.

Configuration
REQ-026 Macro MONT_EXP_CONST_TIME_EN defined: MULT shall execute for every bit; when exp[i]=0 the product is discarded (acc unchanged), count fixed at 3 + 2*WIDTH.
REQ-027 Macro undefined: MULT executes only for exp[i]=1 (REQ-018).

Structure
REQ-028 Shared package mont_pkg shall hold the FSM state enum and the WIDTH default constant, reused by the montgomery core and its benches.
REQ-029 One sub-module mont_mm_if shall own the mm_start/mm_done handshake (issue, wait, capture, release), giving the FSM a req/ack pulse interface.

Verification
REQ-030 Bench uses a behavioural montgomery model, R=2^WIDTH, variable 1-20 cycle mm_done latency.
REQ-031 base=2, exp=10, P=997, R2=R^2 mod 997 -> result=27, done one cycle, 261 mm requests (515 with MONT_EXP_CONST_TIME_EN).
REQ-032 base=3, exp=4, P=89 -> result=81; base=13, exp=88, P=89 -> result=1.
REQ-033 exp=0, base=65, P=997 -> result=1; exp=1 -> result=65.
REQ-034 P=996 -> done=1 and err=1 one cycle after start, result=0, mm_start never asserted.
REQ-035 rst_n low for 3 cycles after 100 mm requests -> all outputs 0, no done; then base=2, exp=10, P=997 -> result=27; start pulses while busy ignored throughout.
